// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter that flags a memory transaction stuck for TIMEOUT cycles.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Count wait cycles; restart whenever the arbiter is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = run & (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (if_*) and
// data (dm_*) requesters. One transaction outstanding at a time; ties go
// to the port not granted last. Misaligned (odd) addresses are rejected
// with a done+err pulse and never reach memory.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a watchdog (arb_watchdog)
// that aborts a wait after TIMEOUT cycles with done+err on the owning port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              if_done,
  output logic              dm_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              if_err,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_dm;
  logic              r_if_done, r_dm_done, r_if_err, r_dm_err;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
  logic              r_mem_req, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_if_pend, w_dm_pend;
  logic              w_pick_if, w_pick_dm;
  logic              w_expired;

  // A request is still being held during its own done cycle; it only
  // counts as a new request from the following cycle on.
  assign w_if_pend = if_req & ~r_if_done;
  assign w_dm_pend = dm_req & ~r_dm_done;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (r_state != IDLE),
    .clear   (r_state == IDLE),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant selection; grants only happen in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pick_if   = 1'b0;
    w_pick_dm   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pick_dm = w_dm_pend & (~w_if_pend | ~r_last_dm);
        w_pick_if = w_if_pend & ~w_pick_dm;
        if (w_pick_dm && !dm_addr[0]) begin
          w_state_nxt = DM_WAIT;
        end else if (w_pick_if && !if_addr[0]) begin
          w_state_nxt = IF_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_done || w_expired) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, completion pulses and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dm   <= 1'b0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_err    <= 1'b0;
      r_dm_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      r_if_err  <= 1'b0;
      r_dm_err  <= 1'b0;
      r_mem_req <= 1'b0;

      if (w_pick_dm) begin
        r_last_dm <= 1'b1;
        if (dm_addr[0]) begin
          r_dm_done <= 1'b1;
          r_dm_err  <= 1'b1;
        end else begin
          r_mem_req   <= 1'b1;
          r_mem_wr    <= dm_wr;
          r_mem_addr  <= dm_addr;
          r_mem_wdata <= dm_wdata;
        end
      end

      if (w_pick_if) begin
        r_last_dm <= 1'b0;
        if (if_addr[0]) begin
          r_if_done <= 1'b1;
          r_if_err  <= 1'b1;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_wr   <= 1'b0;
          r_mem_addr <= if_addr;
        end
      end

      if (r_state == IF_WAIT) begin
        if (mem_done) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= mem_rdata;
        end else if (w_expired) begin
          r_if_done <= 1'b1;
          r_if_err  <= 1'b1;
        end
      end

      if (r_state == DM_WAIT) begin
        if (mem_done) begin
          r_dm_done <= 1'b1;
          if (!r_mem_wr) begin
            r_dm_rdata <= mem_rdata;
          end
        end else if (w_expired) begin
          r_dm_done <= 1'b1;
          r_dm_err  <= 1'b1;
        end
      end
    end
  end

  assign if_done   = r_if_done;
  assign dm_done   = r_dm_done;
  assign if_err    = r_if_err;
  assign dm_err    = r_dm_err;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_stall  = if_req & ~r_if_done;
  assign dm_stall  = dm_req & ~r_dm_done;
  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-port transactions plus
// hand-written sequences for contention, reset during a wait and timeout.
module tb_mem_arbiter;

  localparam int TO = 32;

  logic        clk;
  logic        rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, if_err, dm_err, if_stall, dm_stall;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_req, mem_wr, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .if_done   (if_done),
    .dm_done   (dm_done),
    .if_rdata  (if_rdata),
    .dm_rdata  (dm_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .if_err    (if_err),
    .dm_err    (dm_err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mrdata;
    logic        exp_mreq;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[7];

  int n_tests, n_fail, cyc;
  int n_memreq, n_done, n_ifd, n_dmd, n_ife, n_dme;
  logic [15:0] cap_addr[8];
  logic        cap_wr[8];
  logic [15:0] cap_wdata[8];
  int          done_port[8];
  int          mem_lat, mem_cd;
  logic        mem_pend, mem_resp_en;
  logic [15:0] mem_resp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_memreq = 0; n_done = 0; n_ifd = 0; n_dmd = 0; n_ife = 0; n_dme = 0;
  endtask

  // One clock: advance, then act as the memory and log DUT pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_done = 1'b0;
    if (mem_pend) begin
      if (mem_cd <= 1) begin
        mem_done  = 1'b1;
        mem_rdata = mem_resp;
        mem_pend  = 1'b0;
      end else begin
        mem_cd--;
      end
    end
    if (mem_req === 1'b1) begin
      if (n_memreq < 8) begin
        cap_addr[n_memreq]  = mem_addr;
        cap_wr[n_memreq]    = mem_wr;
        cap_wdata[n_memreq] = mem_wdata;
      end
      n_memreq++;
      if (mem_resp_en) begin
        mem_pend = 1'b1;
        mem_cd   = mem_lat;
      end
    end
    if (if_done === 1'b1) begin
      if (n_done < 8) done_port[n_done] = 0;
      n_done++; n_ifd++;
    end
    if (dm_done === 1'b1) begin
      if (n_done < 8) done_port[n_done] = 1;
      n_done++; n_dmd++;
    end
    if (if_err === 1'b1) n_ife++;
    if (dm_err === 1'b1) n_dme++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0; mem_pend = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int k;
    logic got;
    clr_counts();
    mem_lat = v.lat; mem_resp = v.mrdata; mem_resp_en = 1'b1;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk({nm, " stall"}, v.is_dm ? dm_stall : if_stall, 32'd1);
    got = 1'b0;
    k = 0;
    while (!got && k < 64) begin
      step();
      k++;
      got = v.is_dm ? (n_dmd > 0) : (n_ifd > 0);
    end
    chk({nm, " latency"}, k, v.exp_lat);
    chk({nm, " stall_at_done"}, v.is_dm ? dm_stall : if_stall, 32'd0);
    chk({nm, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk({nm, " err"}, v.is_dm ? dm_err : if_err, v.exp_err);
    chk({nm, " other_done"}, v.is_dm ? n_ifd : n_dmd, 32'd0);
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    step();
    chk({nm, " done_pulse"}, v.is_dm ? dm_done : if_done, 32'd0);
    chk({nm, " mem_req_count"}, n_memreq, v.exp_mreq);
    if (v.exp_mreq) begin
      chk({nm, " mem_addr"}, cap_addr[0], v.addr);
      chk({nm, " mem_wr"}, cap_wr[0], v.wr);
      if (v.wr) chk({nm, " mem_wdata"}, cap_wdata[0], v.wdata);
    end
  endtask

  initial begin
    vec_t post;
    int   k;
    int   t_wait;
    n_tests = 0; n_fail = 0; cyc = 0;
    mem_lat = 1; mem_cd = 0; mem_pend = 1'b0; mem_resp_en = 1'b1; mem_resp = '0;
    clr_counts();

    //            dm  wr  addr      wdata     lat mrdata    mreq rdata     err lat
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'hABCD, 1'b1, 16'hABCD, 1'b0, 5};
    tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'h5A5A, 1'b1, 16'h5A5A, 1'b0, 3};
    tbl[2] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 2, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 4};
    tbl[3] = '{1'b1, 1'b0, 16'h0031, 16'h0000, 1, 16'h0000, 1'b0, 16'h5A5A, 1'b1, 1};
    tbl[4] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1, 16'h0000, 1'b0, 16'hABCD, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 1, 16'h0001, 1'b1, 16'h0001, 1'b0, 3};
    tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 5, 16'h8000, 1'b1, 16'h8000, 1'b0, 7};
    post   = '{1'b0, 1'b0, 16'h0100, 16'h0000, 2, 16'hC0DE, 1'b1, 16'hC0DE, 1'b0, 4};

    // Reset state
    do_reset();
    chk("rst if_done", if_done, 32'd0);
    chk("rst dm_done", dm_done, 32'd0);
    chk("rst if_err", if_err, 32'd0);
    chk("rst dm_err", dm_err, 32'd0);
    chk("rst mem_req", mem_req, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst dm_rdata", dm_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wr", mem_wr, 32'd0);
    chk("rst if_stall", if_stall, 32'd0);
    chk("rst dm_stall", dm_stall, 32'd0);

    // Table of single-port transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], $sformatf("v%0d", i));
    end

    // Both ports requesting from reset: dm first, then strict alternation
    do_reset();
    clr_counts();
    mem_lat = 1; mem_resp = 16'h0BAD; mem_resp_en = 1'b1;
    if_req = 1'b1; if_addr = 16'h0010;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    k = 0;
    while (n_done < 4 && k < 100) begin
      step();
      k++;
    end
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    for (int j = 0; j < 10; j++) step();
    chk("alt reached 4 dones", (n_done >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("alt grant%0d addr", j), cap_addr[j], (j % 2 == 0) ? 32'h0020 : 32'h0010);
      chk($sformatf("alt grant%0d wr", j), cap_wr[j], (j % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt done%0d port", j), done_port[j], (j % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("alt store wdata", cap_wdata[0], 32'h1234);
    chk("alt dm_rdata held on stores", dm_rdata, 32'h0000);
    chk("alt if_rdata", if_rdata, 32'h0BAD);

    // Reset while waiting on a data load, then a stray mem_done
    do_reset();
    clr_counts();
    mem_resp_en = 1'b0;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    k = 0;
    while (n_memreq == 0 && k < 20) begin
      step();
      k++;
    end
    step();
    step();
    chk("rstwait stall before", dm_stall, 32'd1);
    rst = 1'b1;
    dm_req = 1'b0;
    #1;
    chk("rstwait mem_addr", mem_addr, 32'd0);
    chk("rstwait dm_done", dm_done, 32'd0);
    step();
    rst = 1'b0;
    clr_counts();
    mem_done = 1'b1;
    mem_rdata = 16'h7777;
    step();
    step();
    step();
    chk("rstwait no dm_done", n_dmd, 32'd0);
    chk("rstwait no mem_req", n_memreq, 32'd0);
    chk("rstwait dm_rdata", dm_rdata, 32'd0);
    run_txn(post, "rstwait post");

    // Memory never answers
    do_reset();
    clr_counts();
    mem_resp_en = 1'b0;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0050;
    k = 0;
    while (n_memreq == 0 && k < 20) begin
      step();
      k++;
    end
    t_wait = cyc;
`ifdef MEM_ARB_TIMEOUT_EN
    k = 0;
    while (n_dmd == 0 && k < TO + 8) begin
      step();
      k++;
    end
    chk("timeout delay", cyc - t_wait, TO);
    chk("timeout err", n_dme, 32'd1);
    chk("timeout dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    step();
`else
    for (int j = 0; j < TO + 8; j++) step();
    chk("nowatchdog no done", n_dmd, 32'd0);
    chk("nowatchdog stall", dm_stall, 32'd1);
    chk("nowatchdog single mem_req", n_memreq, 32'd1);
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameters: DATA_W, 16, memory word width; ADDR_W, 16, byte address width; TIMEOUT, 32, watchdog limit in cycles.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 if_req  in  1  instruction fetch request, held until if_done.
REQ-005 if_addr  in  ADDR_W  fetch address (PC).
REQ-006 dm_req  in  1  data request, equal to MemToReg|MemWrite of MEM stage, held until dm_done.
REQ-007 dm_wr  in  1  1=store, 0=load.
REQ-008 dm_addr  in  ADDR_W  data address (ALU result).
REQ-009 dm_wdata  in  DATA_W  store data.
REQ-010 if_done, dm_done  out  1 each  one-cycle completion pulse.
REQ-011 if_rdata, dm_rdata  out  DATA_W each  registered read data, valid with the done pulse.
REQ-012 if_stall, dm_stall  out  1 each  req & ~done, combinational.
REQ-013 if_err, dm_err  out  1 each  one-cycle error pulse, coincident with done.
REQ-014 mem_req  out  1  one-cycle memory command strobe.
REQ-015 mem_wr, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  registered command fields, stable from mem_req until mem_done.
REQ-016 mem_done  in  1  memory completion pulse; mem_rdata  in  DATA_W  read data valid with mem_done.

Function
REQ-017 SHALL implement FSM states IDLE, IF_WAIT, DM_WAIT.
REQ-018 IDLE with an aligned request SHALL latch the command, assert mem_req on the next cycle and move to the matching WAIT state.
REQ-019 Requests with address bit 0 set SHALL issue no memory command and SHALL pulse done and err one cycle later, with FSM remaining in IDLE.
REQ-020 When both if_req and dm_req are pending in IDLE, the port not granted last SHALL win; after reset dm wins first.
REQ-021 In a WAIT state, mem_done SHALL cause the owning port's done pulse and rdata update on the next cycle, and a return to IDLE.
REQ-022 For stores, dm_rdata SHALL hold its previous value.
REQ-023 The earliest grant for a new request SHALL be the cycle after a done pulse, so minimum request-to-done latency is mem latency + 2 cycles.
REQ-024 mem_done received in IDLE SHALL be ignored.
REQ-025 At most one memory transaction SHALL be outstanding.

Reset
REQ-026 rst SHALL force state IDLE, last-grant = IF (so dm wins next), and drive all done/err/mem_req outputs to 0, rdata outputs to 0, and mem_addr/mem_wdata/mem_wr to 0.
REQ-027 Reset during a WAIT state SHALL abandon the transaction with no done pulse.

Configuration
REQ-028 With MEM_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT states; if it reaches TIMEOUT-1 without mem_done, the FSM SHALL return to IDLE and pulse the owning port's done and err, leaving rdata unchanged.
REQ-029 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT states SHALL persist until mem_done.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum, the DATA_W/ADDR_W defaults and the TIMEOUT default.
REQ-031 The timeout counter SHALL be sub-module arb_watchdog (inputs clk, rst, run, clear; output expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-032 Case: if_req with if_addr=0x0010 and mem_done returned 3 cycles after mem_req with 0xABCD -> single mem_req with mem_addr=0x0010 and mem_wr=0, then if_done and if_rdata=0xABCD, with if_stall high until then.
REQ-033 Case: if_req and dm_req asserted together from reset, dm a store to 0x0020 with 0x1234 -> dm served first with mem_wr=1, then fetch served, then with both held again dm and if alternate.
REQ-034 Case: dm_req with dm_addr=0x0031 -> no mem_req, dm_done and dm_err pulse one cycle later.
REQ-035 Case: rst asserted in DM_WAIT, then a late mem_done -> no dm_done, FSM in IDLE, late pulse ignored.
REQ-036 Case: with MEM_ARB_TIMEOUT_EN, mem_done withheld -> err and done pulse on the owning port TIMEOUT cycles after the request enters WAIT; without the macro, the stall persists indefinitely.
